switch_core_np: RTL and testbench

- Parametrised N-port packet switch core; successor to the fixed 4-port switch DUT.
- Sources push (addr, data) words. Each word is routed by address match against a programmable port address table into a per-destination FIFO.
- Sinks pop words with a first-word-fall-through rd_en interface.
- Adds over the previous generation: configurable port count, depth and widths; programmable almost-empty/almost-full thresholds; 2-bit per-source priority with round-robin tie-break; unmatched-address drop reporting.

---
 rtl/switch_core_np.sv | 181 ++++++++++++++++++
 tb/tb_switch_core_np.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_core_np.sv
// switch_core_np: N-port packet switch core.
// Source words are routed by exact address match against a programmable
// table into per-destination FWFT FIFOs. Contending sources are resolved
// by a 2-bit priority, with a shared round-robin pointer breaking ties.
// Words whose address matches no table entry are accepted and discarded,
// and a one-cycle drop pulse is raised for that source.
module switch_core_np #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 8,
  parameter int AE_LVL    = 2,
  parameter int AF_LVL    = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PORTS*ADDR_W-1:0]    addr_in,
  input  logic [NUM_PORTS*DATA_W-1:0]    data_in,
  input  logic [NUM_PORTS-1:0]           wr_en,
  output logic [NUM_PORTS-1:0]           data_rcv,
  output logic [NUM_PORTS*ADDR_W-1:0]    addr_out,
  output logic [NUM_PORTS*DATA_W-1:0]    data_out,
  input  logic [NUM_PORTS-1:0]           rd_en,
  output logic [NUM_PORTS-1:0]           data_rdy,
  output logic [NUM_PORTS-1:0]           fifo_empty,
  output logic [NUM_PORTS-1:0]           fifo_full,
  output logic [NUM_PORTS-1:0]           fifo_ae,
  output logic [NUM_PORTS-1:0]           fifo_af,
  output logic [NUM_PORTS-1:0]           drop,
  input  logic                           prio_wr,
  input  logic [2*NUM_PORTS-1:0]         prio_val,
  input  logic                           port_en,
  input  logic                           port_wr,
  input  logic [$clog2(NUM_PORTS)-1:0]   port_sel,
  input  logic [ADDR_W-1:0]              port_addr
);
  localparam int SW = $clog2(NUM_PORTS);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [2*NUM_PORTS-1:0] prio_q, prio_d;
  logic [ADDR_W-1:0]      tbl_q [NUM_PORTS];
  logic [ADDR_W-1:0]      tbl_d [NUM_PORTS];
  logic [SW-1:0]          rr_q, rr_d;
  logic [ADDR_W-1:0]      amem_q [NUM_PORTS][DEPTH];
  logic [DATA_W-1:0]      dmem_q [NUM_PORTS][DEPTH];
  logic [PW-1:0]          wr_ptr_q [NUM_PORTS];
  logic [PW-1:0]          rd_ptr_q [NUM_PORTS];
  logic [CW-1:0]          cnt_q [NUM_PORTS];
  logic [CW-1:0]          cnt_d [NUM_PORTS];
  logic [NUM_PORTS-1:0]   empty_q, full_q, ae_q, af_q, drop_q, drop_d;
  logic [NUM_PORTS-1:0]   hit_s, push_s, pop_s, grant_s;
  logic [SW-1:0]          tgt_s [NUM_PORTS];
  logic [SW-1:0]          win_s [NUM_PORTS];

  // Next-state of the priority register and the address table.
  always_comb begin
    prio_d = prio_wr ? prio_val : prio_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      tbl_d[p] = (port_wr && (int'(port_sel) == p)) ? port_addr : tbl_q[p];
    end
  end

  // Address lookup: scanning downward makes the lowest matching entry win.
  always_comb begin
    hit_s = '0;
    for (int s = 0; s < NUM_PORTS; s++) begin
      tgt_s[s] = '0;
      for (int p = NUM_PORTS - 1; p >= 0; p--) begin
        hit_s[s] = hit_s[s] | (addr_in[s*ADDR_W +: ADDR_W] == tbl_q[p]);
        tgt_s[s] = (addr_in[s*ADDR_W +: ADDR_W] == tbl_q[p]) ? SW'(p) : tgt_s[s];
      end
    end
  end

  // Per-destination arbitration: highest priority, then round-robin on ties.
  always_comb begin
    logic [NUM_PORTS-1:0] cand;
    logic [NUM_PORTS-1:0] tied;
    logic [1:0]           best;
    logic                 found;
    int                   ntied;
    int                   idx;
    push_s  = '0;
    grant_s = '0;
    rr_d    = rr_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      win_s[p] = '0;
      best     = 2'd0;
      found    = 1'b0;
      ntied    = 0;
      for (int s = 0; s < NUM_PORTS; s++) begin
        cand[s] = port_en & wr_en[s] & hit_s[s] & (int'(tgt_s[s]) == p);
        best = (cand[s] && (prio_q[2*s +: 2] > best)) ? prio_q[2*s +: 2] : best;
      end
      for (int s = 0; s < NUM_PORTS; s++) begin
        tied[s] = cand[s] && (prio_q[2*s +: 2] == best);
        ntied   = ntied + int'(tied[s]);
      end
      for (int k = 0; k < NUM_PORTS; k++) begin
        idx      = (int'(rr_q) + k) % NUM_PORTS;
        win_s[p] = (tied[idx] && !found) ? SW'(idx) : win_s[p];
        found    = found | tied[idx];
      end
      // A full FIFO still arbitrates but refuses the push, even on a pop cycle.
      push_s[p]         = found & ~full_q[p];
      grant_s[win_s[p]] = grant_s[win_s[p]] | push_s[p];
      rr_d = (ntied > 1) ? SW'((int'(win_s[p]) + 1) % NUM_PORTS) : rr_d;
    end
  end

  // Acceptance, drop detection, pop qualification and next FIFO counts.
  always_comb begin
    for (int s = 0; s < NUM_PORTS; s++) begin
      drop_d[s]   = port_en & wr_en[s] & ~hit_s[s];
      data_rcv[s] = grant_s[s] | drop_d[s];
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      pop_s[p] = rd_en[p] & ~empty_q[p];
      cnt_d[p] = cnt_q[p] + CW'(push_s[p]) - CW'(pop_s[p]);
    end
  end

  // Head-of-FIFO outputs, forced to zero while a FIFO is empty.
  always_comb begin
    data_rdy   = ~empty_q;
    fifo_empty = empty_q;
    fifo_full  = full_q;
    fifo_ae    = ae_q;
    fifo_af    = af_q;
    drop       = drop_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      data_out[p*DATA_W +: DATA_W] = empty_q[p] ? '0 : dmem_q[p][rd_ptr_q[p]];
      addr_out[p*ADDR_W +: ADDR_W] = empty_q[p] ? '0 : amem_q[p][rd_ptr_q[p]];
    end
  end

  // Control state: config registers, rr pointer, FIFO pointers, counts and flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_q  <= '0;
      rr_q    <= '0;
      drop_q  <= '0;
      empty_q <= '1;
      full_q  <= '0;
      ae_q    <= '1;
      af_q    <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        tbl_q[p]    <= ADDR_W'(p);
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
        cnt_q[p]    <= '0;
      end
    end else begin
      prio_q <= prio_d;
      rr_q   <= rr_d;
      drop_q <= drop_d;
      for (int p = 0; p < NUM_PORTS; p++) begin
        tbl_q[p]    <= tbl_d[p];
        wr_ptr_q[p] <= wr_ptr_q[p] + PW'(push_s[p]);
        rd_ptr_q[p] <= rd_ptr_q[p] + PW'(pop_s[p]);
        cnt_q[p]    <= cnt_d[p];
        empty_q[p]  <= (cnt_d[p] == CW'(0));
        full_q[p]   <= (cnt_d[p] == CW'(DEPTH));
        ae_q[p]     <= (cnt_d[p] <= CW'(AE_LVL));
        af_q[p]     <= (cnt_d[p] >= CW'(DEPTH - AF_LVL));
      end
    end
  end

  // FIFO storage: written with the winning source's word on each push.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (push_s[p]) begin
        amem_q[p][wr_ptr_q[p]] <= addr_in[int'(win_s[p])*ADDR_W +: ADDR_W];
        dmem_q[p][wr_ptr_q[p]] <= data_in[int'(win_s[p])*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_switch_core_np.sv
// Directed self-checking bench for switch_core_np (4 ports, 16-bit fields, depth 8).
module tb_switch_core_np;
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] addr_in, data_in, addr_out, data_out;
  logic [3:0]  wr_en, data_rcv, rd_en, data_rdy;
  logic [3:0]  fifo_empty, fifo_full, fifo_ae, fifo_af, drop;
  logic        prio_wr, port_en, port_wr;
  logic [7:0]  prio_val;
  logic [1:0]  port_sel;
  logic [15:0] port_addr;
  int          n_cmp = 0;
  int          n_err = 0;
  int          k0, k3;

  switch_core_np dut (
    .clk(clk), .reset(reset), .addr_in(addr_in), .data_in(data_in), .wr_en(wr_en),
    .data_rcv(data_rcv), .addr_out(addr_out), .data_out(data_out), .rd_en(rd_en),
    .data_rdy(data_rdy), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_ae(fifo_ae), .fifo_af(fifo_af), .drop(drop), .prio_wr(prio_wr),
    .prio_val(prio_val), .port_en(port_en), .port_wr(port_wr),
    .port_sel(port_sel), .port_addr(port_addr)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic [15:0] a, input logic [15:0] d, input logic w);
    addr_in[s*16 +: 16] = a;
    data_in[s*16 +: 16] = d;
    wr_en[s]            = w;
  endtask

  function automatic logic [15:0] dout(input int p);
    return data_out[p*16 +: 16];
  endfunction

  function automatic logic [15:0] aout(input int p);
    return addr_out[p*16 +: 16];
  endfunction

  initial begin
    reset = 1'b0; addr_in = '0; data_in = '0; wr_en = '0; rd_en = '0;
    prio_wr = 1'b0; prio_val = '0; port_en = 1'b1; port_wr = 1'b0;
    port_sel = '0; port_addr = '0;
    tick; tick;
    // Reset state
    check_value("rst_empty", fifo_empty, 64'hF);
    check_value("rst_ae", fifo_ae, 64'hF);
    check_value("rst_full", fifo_full, 64'h0);
    check_value("rst_af", fifo_af, 64'h0);
    check_value("rst_rdy", data_rdy, 64'h0);
    check_value("rst_dout", data_out, 64'h0);
    check_value("rst_aout", addr_out, 64'h0);
    check_value("rst_drop", drop, 64'h0);
    reset = 1'b1;
    tick;

    // Basic route: source 0 -> dest 2
    set_src(0, 16'd2, 16'hA5A5, 1'b1);
    #1 check_value("t1_rcv", data_rcv, 64'h1);
    tick;
    set_src(0, 16'd0, 16'd0, 1'b0);
    check_value("t1_rdy", data_rdy, 64'h4);
    check_value("t1_dout", dout(2), 64'hA5A5);
    check_value("t1_aout", aout(2), 64'h2);
    rd_en[2] = 1'b1;
    tick;
    rd_en[2] = 1'b0;
    check_value("t1_empty", fifo_empty, 64'hF);

    // Fill dest 1, check af/full, then a held 9th word
    for (int i = 0; i < 8; i++) begin
      set_src(1, 16'd1, 16'h1000 + 16'(i), 1'b1);
      #1 check_value("t2_rcv", data_rcv[1], 64'h1);
      tick;
      check_value("t2_af", fifo_af[1], (i + 1 >= 6) ? 64'h1 : 64'h0);
      check_value("t2_full", fifo_full[1], (i + 1 == 8) ? 64'h1 : 64'h0);
    end
    set_src(1, 16'd1, 16'h1008, 1'b1);
    #1 check_value("t2_held0", data_rcv[1], 64'h0);
    tick;
    check_value("t2_held1", data_rcv[1], 64'h0);
    rd_en[1] = 1'b1;
    #1 check_value("t2_popfull", data_rcv[1], 64'h0);
    tick;
    rd_en[1] = 1'b0;
    check_value("t2_notfull", fifo_full[1], 64'h0);
    check_value("t2_acc", data_rcv[1], 64'h1);
    check_value("t2_head", dout(1), 64'h1001);
    tick;
    set_src(1, 16'd0, 16'd0, 1'b0);
    check_value("t2_refull", fifo_full[1], 64'h1);
    rd_en[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_value("t2_drain", dout(1), 64'h1001 + 64'(i));
      tick;
    end
    rd_en[1] = 1'b0;
    check_value("t2_empty", fifo_empty[1], 64'h1);

    // Priority: source 3 (prio 2) beats source 0 (prio 1)
    prio_val = {2'd2, 2'd0, 2'd0, 2'd1};
    prio_wr = 1'b1;
    tick;
    prio_wr = 1'b0;
    set_src(0, 16'd0, 16'hA000, 1'b1);
    set_src(3, 16'd0, 16'hD000, 1'b1);
    #1 check_value("t3_prio_a", data_rcv, 64'h8);
    tick;
    set_src(3, 16'd0, 16'd0, 1'b0);
    #1 check_value("t3_prio_b", data_rcv, 64'h1);
    tick;
    set_src(0, 16'd0, 16'd0, 1'b0);
    check_value("t3_head_a", dout(0), 64'hD000);
    rd_en[0] = 1'b1;
    tick;
    check_value("t3_head_b", dout(0), 64'hA000);
    tick;
    rd_en[0] = 1'b0;
    check_value("t3_empty", fifo_empty[0], 64'h1);

    // Equal priority: round-robin alternates 0,3,0,3
    prio_val = 8'h00;
    prio_wr = 1'b1;
    tick;
    prio_wr = 1'b0;
    k0 = 0; k3 = 0;
    for (int c = 0; c < 4; c++) begin
      set_src(0, 16'd0, 16'hB000 + 16'(k0), 1'b1);
      set_src(3, 16'd0, 16'hC000 + 16'(k3), 1'b1);
      #1 check_value("t3_rr", data_rcv, (c % 2 == 0) ? 64'h1 : 64'h8);
      if (c % 2 == 0) k0++; else k3++;
      tick;
    end
    set_src(0, 16'd0, 16'd0, 1'b0);
    set_src(3, 16'd0, 16'd0, 1'b0);
    rd_en[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_value("t3_rr_order", dout(0), ((i % 2 == 0) ? 64'hB000 : 64'hC000) + 64'(i / 2));
      tick;
    end
    rd_en[0] = 1'b0;

    // Table write, then routing and an unmatched-address drop
    port_sel = 2'd1; port_addr = 16'h0100; port_wr = 1'b1;
    tick;
    port_wr = 1'b0;
    set_src(2, 16'h0100, 16'h5555, 1'b1);
    #1 check_value("t4_rcv", data_rcv, 64'h4);
    tick;
    set_src(2, 16'h0001, 16'h6666, 1'b1);
    #1 check_value("t4_drop_rcv", data_rcv, 64'h4);
    check_value("t4_rdy", data_rdy, 64'h2);
    check_value("t4_dout", dout(1), 64'h5555);
    check_value("t4_aout", aout(1), 64'h0100);
    check_value("t4_nodrop", drop, 64'h0);
    tick;
    set_src(2, 16'd0, 16'd0, 1'b0);
    check_value("t4_drop", drop, 64'h4);
    check_value("t4_rdy2", data_rdy, 64'h2);
    tick;
    check_value("t4_drop_end", drop, 64'h0);
    rd_en[1] = 1'b1;
    tick;
    rd_en[1] = 1'b0;
    check_value("t4_empty", fifo_empty, 64'hF);

    // Fill every FIFO to 5 words, then reset mid-burst
    for (int c = 0; c < 5; c++) begin
      for (int s = 0; s < 4; s++) begin
        set_src(s, (s == 1) ? 16'h0100 : 16'(s), 16'(s * 256 + c), 1'b1);
      end
      #1 check_value("t5_rcv", data_rcv, 64'hF);
      tick;
    end
    check_value("t5_rdy", data_rdy, 64'hF);
    check_value("t5_ae", fifo_ae, 64'h0);
    check_value("t5_af", fifo_af, 64'h0);
    reset = 1'b0;
    #1;
    check_value("t5_empty", fifo_empty, 64'hF);
    check_value("t5_ae_rst", fifo_ae, 64'hF);
    check_value("t5_full", fifo_full, 64'h0);
    check_value("t5_rdy_rst", data_rdy, 64'h0);
    check_value("t5_dout", data_out, 64'h0);
    check_value("t5_aout", addr_out, 64'h0);
    wr_en = '0;
    tick;
    reset = 1'b1;
    tick;
    set_src(1, 16'd1, 16'h7777, 1'b1);
    #1 check_value("t5_post_rcv", data_rcv, 64'h2);
    tick;
    set_src(1, 16'd0, 16'd0, 1'b0);
    check_value("t5_post_rdy", data_rdy, 64'h2);
    check_value("t5_post_dout", dout(1), 64'h7777);
    rd_en[1] = 1'b1;
    tick;
    rd_en[1] = 1'b0;

    // Ingress disabled: no accepts, no drops, draining still works
    set_src(0, 16'd3, 16'h3001, 1'b1);
    tick;
    set_src(0, 16'd3, 16'h3002, 1'b1);
    tick;
    port_en = 1'b0;
    set_src(0, 16'd3, 16'h3003, 1'b1);
    set_src(2, 16'h0009, 16'h3004, 1'b1);
    #1 check_value("t6_rcv", data_rcv, 64'h0);
    tick;
    check_value("t6_rdy", data_rdy, 64'h8);
    check_value("t6_drop", drop, 64'h0);
    check_value("t6_ae", fifo_ae, 64'hF);
    rd_en[3] = 1'b1;
    check_value("t6_head_a", dout(3), 64'h3001);
    tick;
    check_value("t6_head_b", dout(3), 64'h3002);
    check_value("t6_rcv2", data_rcv, 64'h0);
    tick;
    rd_en[3] = 1'b0;
    check_value("t6_empty", fifo_empty, 64'hF);
    check_value("t6_drop2", drop, 64'h0);
    wr_en = '0;
    port_en = 1'b1;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Guards against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
